mux_scan_sampler: RTL and testbench
===================================

# mux_scan_sampler

Sequencer that sits directly upstream of the 5:1 `mux5` select path. It drives the mux select `s` through channels 0..N-1, waits a programmable settle time per channel, and samples the mux output `y` into an N-bit word. The completed word is presented on a valid/ready output handshake. This lets a single-bit mux channel be read back as a parallel word by downstream logic.

## Interface
- `N`, default 5: number of mux channels scanned; must match the mux width.
- `SEL_W`, default 3: select width; must satisfy 2**SEL_W >= N.
- `SETTLE`, default 1: idle cycles after each select change before sampling; 0 allowed.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a scan; sampled only when idle, or at the handshake edge in HOLD.
- `busy`  out  1  high from the accepted start until the word handshake completes.
- `s`  out  SEL_W  mux select; registered.
- `y`  in  1  mux output for the current `s`.
- `word`  out  N  sampled result; bit i = `y` observed while `s`==i.
- `valid`  out  1  `word` complete and stable.
- `ready`  in  1  consumer accepts `word` on an edge where `valid` && `ready`.

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE, `start`=1: `s`←0, `cnt`←0, `busy`←1. Next state is SETTLE, or SAMPLE if `SETTLE`=0.
- SETTLE: `cnt`←`cnt`+1 each edge. At the edge where `cnt`==SETTLE-1, go to SAMPLE.
- SAMPLE (one cycle): `word[s]`←`y`.
  - If `s`==N-1: go to HOLD and set `valid`←1.
  - Otherwise: `s`←`s`+1, `cnt`←0, then SETTLE (or SAMPLE if `SETTLE`=0).
- HOLD: `word`, `s` and `valid` are held.
  - On `valid` && `ready`: `valid`←0.
  - If `start`=1 on that same edge: begin a new scan as from IDLE (back-to-back, `busy` stays 1).
  - Otherwise: go to IDLE and set `busy`←0.
- `s` never leaves 0..N-1. The mux returns 0 for out-of-range selects, so an out-of-range select would silently corrupt data.
- `s` returns to 0 in IDLE.
- `word` bits from a previous scan remain visible until overwritten. Only the contents of `word` while `valid`=1 are defined.
- `start` in SETTLE or SAMPLE is ignored. `ready` while `valid`=0 is ignored.
- `cnt` width is clog2(SETTLE+1), minimum 1 bit.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, `s`=0, `cnt`=0, `word`=0, `valid`=0, `busy`=0.
- Reset mid-scan aborts immediately. No partial word is ever presented.
- Deassertion is synchronous to `clk` (external synchronizer).
- Per channel: SETTLE+1 cycles.
- `valid` rises at the N·(SETTLE+1)-th edge after the start-accept edge. With defaults, this is 10 edges.
- `y` is sampled on the last edge of a channel slot, so it sees `s` stable for ≥ SETTLE+1 cycles. The combinational mux path must settle within one cycle.
- `busy` is registered. It rises on the start-accept edge and falls on the handshake edge, unless a back-to-back scan starts.
- The handshake completes in the same cycle `ready` is seen; there is no extra wait state.

## Structure
- Package `mux_scan_pkg`: `typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} scan_state_t`.
- Single module with no sub-module. The FSM, select counter and settle counter are one `always_ff` plus next-state `always_comb`.
- System-level bench: instantiate `mux5` with `a` driven by the bench, feeding `y` and taking `s`.

## Test plan
- Defaults, `a`=5'b10110, `start` pulse, `ready`=1 → `valid` high 10 edges later, `word`=5'b10110; `s` sequence 0,0,1,1,2,2,3,3,4,4.
- `SETTLE`=0, `a`=5'b01001 → `valid` 5 edges after start, `word`=5'b01001.
- `ready` held 0 for 7 cycles after `valid` → `word`/`valid` stable; `start` pulses during the scan are ignored; handshake edge → `busy`=0.
- `start`=1 and `ready`=1 on the handshake edge, `a` changed to 5'b11111 → `busy` stays 1; second `word`=5'b11111 after another 10 edges.
- `rst_n` asserted during channel 2 → outputs zero immediately, no `valid`; next scan after release completes correctly.
- Random `a`, 200 scans with random `ready` delays → scoreboard `word`==`a` every handshake; assert `s`<N on every cycle.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types for the mux scan sampler
package mux_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_HOLD
   } scan_state_t;

endpackage

// File: rtl/mux5.sv
// rtl/mux5.sv - 5:1 single-bit mux, returns 0 for out-of-range selects
module mux5 (
   input  logic [4:0] a,
   input  logic [2:0] s,
   output logic       y
);

   always_comb begin
      y = 1'b0;
      case (s)
         3'd0:    y = a[0];
         3'd1:    y = a[1];
         3'd2:    y = a[2];
         3'd3:    y = a[3];
         3'd4:    y = a[4];
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - steps a mux select over N channels, samples y into a word
// and presents the word on a valid/ready handshake.
module mux_scan_sampler
   import mux_scan_pkg::*;
#(
   parameter int N      = 5,
   parameter int SEL_W  = 3,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic [SEL_W-1:0] s,
   input  logic             y,
   output logic [N-1:0]     word,
   output logic             valid,
   input  logic             ready
);

   localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [SEL_W-1:0] S_LAST   = SEL_W'(N - 1);
   // With no settle time every channel slot is a single SAMPLE cycle.
   localparam scan_state_t FIRST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

   scan_state_t      state, state_next;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = FIRST;
         S_SETTLE: if (cnt == CNT_LAST) state_next = S_SAMPLE;
         S_SAMPLE: state_next = (s == S_LAST) ? S_HOLD : FIRST;
         S_HOLD:   if (ready) state_next = start ? FIRST : S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         s     <= '0;
         cnt   <= '0;
         word  <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               s   <= '0;
               cnt <= '0;
               if (start) busy <= 1'b1;
            end
            S_SETTLE: cnt <= cnt + 1'b1;
            S_SAMPLE: begin
               for (int i = 0; i < N; i++) begin
                  if (s == SEL_W'(i)) word[i] <= y;
               end
               if (s == S_LAST) begin
                  valid <= 1'b1;
               end else begin
                  s   <= s + 1'b1;
                  cnt <= '0;
               end
            end
            S_HOLD: begin
               if (ready) begin
                  valid <= 1'b0;
                  s     <= '0;
                  cnt   <= '0;
                  if (!start) busy <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - system bench: sampler driving mux5, checked against
// the expectation that each handshaken word equals the mux inputs.
module tb_mux_scan_sampler;

   localparam int LAT0 = 5 * (1 + 1);
   localparam int LAT1 = 5 * (0 + 1);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [4:0] a0 = '0;
   logic       start0 = 1'b0, ready0 = 1'b0;
   logic       busy0, y0, valid0;
   logic [2:0] s0;
   logic [4:0] word0;

   logic [4:0] a1 = '0;
   logic       start1 = 1'b0, ready1 = 1'b0;
   logic       busy1, y1, valid1;
   logic [2:0] s1;
   logic [4:0] word1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_scan_sampler #(.N(5), .SEL_W(3), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .s(s0),
      .y(y0), .word(word0), .valid(valid0), .ready(ready0)
   );
   mux5 u_mux0 (.a(a0), .s(s0), .y(y0));

   mux_scan_sampler #(.N(5), .SEL_W(3), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .s(s1),
      .y(y1), .word(word1), .valid(valid1), .ready(ready1)
   );
   mux5 u_mux1 (.a(a1), .s(s1), .y(y1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("s0_range", 32'(s0 < 3'd5), 1);
         check("s1_range", 32'(s1 < 3'd5), 1);
      end
   end

   task automatic wait_valid0(output int n);
      n = 0;
      while (!valid0 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_scan(input logic [4:0] av, input int hold, input bit noisy);
      int n;
      @(negedge clk);
      a0 = av; start0 = 1'b1; ready0 = 1'b0;
      @(negedge clk);
      start0 = 1'b0;
      check("busy_rise", busy0, 1);
      n = 0;
      while (!valid0 && n < 40) begin
         if (noisy) start0 = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      start0 = 1'b0;
      check("latency", n, LAT0);
      check("word", word0, av);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", valid0, 1);
         check("hold_word", word0, av);
         check("hold_busy", busy0, 1);
      end
      ready0 = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      check("valid_fall", valid0, 0);
      check("busy_fall", busy0, 0);
      check("s_idle", s0, 0);
   endtask

   initial begin
      int n;
      logic [4:0] av;

      repeat (3) @(negedge clk);
      check("rst_valid0", valid0, 0);
      check("rst_busy0", busy0, 0);
      check("rst_word0", word0, 0);
      check("rst_s0", s0, 0);
      check("rst_valid1", valid1, 0);
      check("rst_word1", word1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Defaults: select sequence and latency, ready held high.
      a0 = 5'b10110; start0 = 1'b1; ready0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < LAT0; k++) begin
         check("s_seq", s0, k / 2);
         check("valid_early", valid0, 0);
         @(negedge clk);
      end
      check("valid_rise", valid0, 1);
      check("word_10110", word0, 5'b10110);
      @(negedge clk);
      ready0 = 1'b0;
      check("hs_valid", valid0, 0);
      check("hs_busy", busy0, 0);

      // SETTLE=0 instance.
      @(negedge clk);
      a1 = 5'b01001; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!valid1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("lat_settle0", n, LAT1);
      check("word_01001", word1, 5'b01001);
      ready1 = 1'b1;
      @(negedge clk);
      ready1 = 1'b0;
      check("hs1_valid", valid1, 0);
      check("hs1_busy", busy1, 0);

      // Long hold with start noise during the scan.
      do_scan(5'b01101, 7, 1'b1);

      // Back-to-back scan started on the handshake edge.
      @(negedge clk);
      a0 = 5'b00110; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_valid0(n);
      check("b2b_first", word0, 5'b00110);
      a0 = 5'b11111; start0 = 1'b1; ready0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; ready0 = 1'b0;
      check("b2b_busy", busy0, 1);
      check("b2b_valid", valid0, 0);
      wait_valid0(n);
      check("b2b_latency", n, LAT0);
      check("b2b_word", word0, 5'b11111);
      ready0 = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      check("b2b_end_busy", busy0, 0);

      // Reset during channel 2 aborts the scan.
      @(negedge clk);
      a0 = 5'b10101; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_s", s0, 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", valid0, 0);
      check("arst_busy", busy0, 0);
      check("arst_word", word0, 0);
      check("arst_s", s0, 0);
      repeat (2) @(negedge clk);
      check("arst_hold_valid", valid0, 0);
      rst_n = 1'b1;
      do_scan(5'b10011, 0, 1'b0);

      // Randomised scans: every handshaken word must equal the mux inputs.
      for (int i = 0; i < 200; i++) begin
         av = 5'($urandom);
         do_scan(av, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
